// File: rtl/slipstream_pkg.sv
// Shared Slipstream clocking types and constants.
// Used by ss_clock_gen (optional halt handshake: SS_CLKGEN_HALT_EN).
package slipstream_pkg;

   typedef enum logic [1:0] {
      PRESET = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } ss_clkgen_state_t;

   localparam int SS_DIV_MIN = 2;

   // Gate clock needs an even divider so both halves are the same length.
   function automatic bit ss_div_ok(input int div);
      return (div >= SS_DIV_MIN) && ((div % 2) == 0);
   endfunction

endpackage

// File: rtl/ss_phase_counter.sv
// Free-running 0..DIV-1 phase counter that flags the updates carrying the
// gate-clock rise (DIV/2-1 -> DIV/2) and fall (DIV-1 -> 0).
module ss_phase_counter
   import slipstream_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic MasterClock,
   input  logic clear,
   input  logic freeze,
   output logic rise,
   output logic fall
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] RISE_AT = PW'(DIV / 2 - 1);
   localparam logic [PW-1:0] LAST    = PW'(DIV - 1);

   logic [PW-1:0] phase;

   always_ff @(posedge MasterClock) begin
      if (clear || freeze || (phase == LAST))
         phase <= '0;
      else
         phase <= phase + 1'b1;
   end

   // Indications describe the update about to happen, so a frozen counter makes no edges.
   assign rise = !freeze && (phase == RISE_AT);
   assign fall = !freeze && (phase == LAST);

endmodule

// File: rtl/ss_clock_gen.sv
// Slipstream gate clock, edge strobes and active-low preset source.
// Define SS_CLKGEN_HALT_EN to compile in the HALTED state and haltReq/haltAck handshake.
module ss_clock_gen
   import slipstream_pkg::*;
#(
   parameter int DIV           = 4,
   parameter int PRESET_CYCLES = 2
) (
   input  logic MasterClock,
   input  logic resetL,
   input  logic haltReq,
   output logic clk,
   output logic clkRise,
   output logic clkFall,
   output logic sL,
   output logic haltAck
);

   if (!ss_div_ok(DIV)) begin : g_div_check
      $error("ss_clock_gen: DIV must be even and >= %0d", SS_DIV_MIN);
   end

   localparam int CNT_W = (PRESET_CYCLES > 0) ? $clog2(PRESET_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESET_CYCLES);

   ss_clkgen_state_t state;
   logic [CNT_W-1:0] preset_cnt;
   logic             edge_rise;
   logic             edge_fall;

   ss_phase_counter #(.DIV(DIV)) u_phase (
      .MasterClock (MasterClock),
      .clear       (!resetL),
      .freeze      (state == HALTED),
      .rise        (edge_rise),
      .fall        (edge_fall)
   );

`ifndef SS_CLKGEN_HALT_EN
   logic unused_halt_req;
   assign unused_halt_req = haltReq;
   assign haltAck = 1'b0;
`endif

   // Edges follow the phase counter in every state; HALTED freezes it so no edges occur there.
   always_ff @(posedge MasterClock) begin
      if (!resetL) begin
         state      <= PRESET;
         preset_cnt <= '0;
         clk        <= 1'b0;
         clkRise    <= 1'b0;
         clkFall    <= 1'b0;
         sL         <= 1'b0;
`ifdef SS_CLKGEN_HALT_EN
         haltAck    <= 1'b0;
`endif
      end else begin
         clkRise <= edge_rise;
         clkFall <= edge_fall;
         if (edge_rise)
            clk <= 1'b1;
         else if (edge_fall)
            clk <= 1'b0;

         case (state)
            PRESET: begin
               if (PRESET_CYCLES == 0) begin
                  sL    <= 1'b1;
                  state <= RUN;
               end else begin
                  if (edge_rise && (preset_cnt != CNT_MAX))
                     preset_cnt <= preset_cnt + 1'b1;
                  if (edge_fall && (preset_cnt == CNT_MAX)) begin
                     sL    <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
`ifdef SS_CLKGEN_HALT_EN
               if (haltReq && edge_fall) begin
                  state   <= HALTED;
                  haltAck <= 1'b1;
               end
`endif
            end
`ifdef SS_CLKGEN_HALT_EN
            HALTED: begin
               clk <= 1'b0;
               if (!haltReq) begin
                  haltAck <= 1'b0;
                  state   <= RUN;
               end
            end
`endif
            default: state <= PRESET;
         endcase
      end
   end

endmodule

// File: tb/tb_ss_clock_gen.sv
// Directed bench for ss_clock_gen: preset release, halt handshake (or its absence), reset pulse, DIV=2.
module tb_ss_clock_gen;

   logic MasterClock = 1'b0;
   always #5 MasterClock = ~MasterClock;

   logic resetL, haltReq, clk, clkRise, clkFall, sL, haltAck;
   logic aux_reset_l, aux_halt;
   logic z_clk, z_rise, z_fall, z_sl, z_ack;
   logic t_clk, t_rise, t_fall, t_sl, t_ack;

   int checks = 0;
   int errors = 0;

   ss_clock_gen #(.DIV(4), .PRESET_CYCLES(2)) dut (
      .MasterClock (MasterClock), .resetL (resetL), .haltReq (haltReq),
      .clk (clk), .clkRise (clkRise), .clkFall (clkFall), .sL (sL), .haltAck (haltAck)
   );

   ss_clock_gen #(.DIV(4), .PRESET_CYCLES(0)) dut_p0 (
      .MasterClock (MasterClock), .resetL (aux_reset_l), .haltReq (aux_halt),
      .clk (z_clk), .clkRise (z_rise), .clkFall (z_fall), .sL (z_sl), .haltAck (z_ack)
   );

   ss_clock_gen #(.DIV(2), .PRESET_CYCLES(1)) dut_d2 (
      .MasterClock (MasterClock), .resetL (aux_reset_l), .haltReq (aux_halt),
      .clk (t_clk), .clkRise (t_rise), .clkFall (t_fall), .sL (t_sl), .haltAck (t_ack)
   );

   // Expected outputs packed as {clk, clkRise, clkFall, sL, haltAck}.
   typedef struct {
      logic       reset_l;
      logic       halt_req;
      logic [4:0] expect_out;
   } vec_t;

   vec_t vecs[12];

   task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: clk/rise/fall/sL/ack got %b, want %b", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic h);
      resetL  = r;
      haltReq = h;
      @(posedge MasterClock);
      #1;
   endtask

   task automatic runTable(input string tag);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].reset_l, vecs[i].halt_req);
         checkOutput($sformatf("%s[%0d]", tag, i), {clk, clkRise, clkFall, sL, haltAck},
                     vecs[i].expect_out);
      end
   endtask

   initial begin
      resetL      = 1'b0;
      haltReq     = 1'b0;
      aux_reset_l = 1'b0;
      aux_halt    = 1'b0;

      // Two reset edges, then updates 1..10 after release with haltReq held during PRESET.
      vecs[0]  = '{1'b0, 1'b0, 5'b00000};
      vecs[1]  = '{1'b0, 1'b1, 5'b00000};
      vecs[2]  = '{1'b1, 1'b1, 5'b00000};
      vecs[3]  = '{1'b1, 1'b1, 5'b11000};
      vecs[4]  = '{1'b1, 1'b1, 5'b10000};
      vecs[5]  = '{1'b1, 1'b1, 5'b00100};
      vecs[6]  = '{1'b1, 1'b1, 5'b00000};
      vecs[7]  = '{1'b1, 1'b1, 5'b11000};
      vecs[8]  = '{1'b1, 1'b1, 5'b10000};
      vecs[9]  = '{1'b1, 1'b1, 5'b00110};
      vecs[10] = '{1'b1, 1'b1, 5'b00010};
      vecs[11] = '{1'b1, 1'b1, 5'b11010};

      runTable("preset");

`ifdef SS_CLKGEN_HALT_EN
      applyStimulus(1'b1, 1'b1);
      checkOutput("pre_halt", {clk, clkRise, clkFall, sL, haltAck}, 5'b10010);
      applyStimulus(1'b1, 1'b1);
      checkOutput("halt_fall", {clk, clkRise, clkFall, sL, haltAck}, 5'b00111);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput($sformatf("halted[%0d]", i), {clk, clkRise, clkFall, sL, haltAck}, 5'b00011);
      end
      applyStimulus(1'b1, 1'b0);
      checkOutput("resume_ack", {clk, clkRise, clkFall, sL, haltAck}, 5'b00010);
      applyStimulus(1'b1, 1'b0);
      checkOutput("resume_wait", {clk, clkRise, clkFall, sL, haltAck}, 5'b00010);
      applyStimulus(1'b1, 1'b0);
      checkOutput("resume_rise", {clk, clkRise, clkFall, sL, haltAck}, 5'b11010);
`else
      // haltReq stays high; the clock must keep running with phase = update mod 4.
      for (int k = 11; k <= 18; k++) begin
         int ph;
         ph = k % 4;
         applyStimulus(1'b1, 1'b1);
         checkOutput($sformatf("no_halt[%0d]", k),
                     {clk, clkRise, clkFall, sL, haltAck},
                     {ph >= 2, ph == 2, ph == 0, 1'b1, 1'b0});
      end
`endif

      // clk is high here; the first table entry is a reset pulse in RUN.
      runTable("rerun");

`ifdef SS_CLKGEN_HALT_EN
      aux_halt = 1'b0;
`else
      aux_halt = 1'b1;
`endif
      for (int i = 0; i < 2; i++) begin
         @(posedge MasterClock);
         #1;
         checkOutput($sformatf("p0_reset[%0d]", i), {z_clk, z_rise, z_fall, z_sl, z_ack}, 5'b00000);
         checkOutput($sformatf("d2_reset[%0d]", i), {t_clk, t_rise, t_fall, t_sl, t_ack}, 5'b00000);
      end
      aux_reset_l = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         int ph;
         ph = k % 4;
         @(posedge MasterClock);
         #1;
         checkOutput($sformatf("p0_run[%0d]", k), {z_clk, z_rise, z_fall, z_sl, z_ack},
                     {ph >= 2, ph == 2, ph == 0, 1'b1, 1'b0});
         checkOutput($sformatf("d2_run[%0d]", k), {t_clk, t_rise, t_fall, t_sl, t_ack},
                     {(k % 2) == 1, (k % 2) == 1, (k % 2) == 0, k >= 2, 1'b0});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
